// File: rtl/uart_send_queue.sv
// Byte queue between the bus controller's UART send strobe and the monitor's send port.
// Bytes are buffered in a circular buffer and forwarded one at a time with a trigger/busy handshake.
module uart_send_queue #(
    parameter int DEPTH_LOG2 = 4,
    parameter int BUSY_WAIT  = 8
) (
    input  logic                  MCLK_IN,
    input  logic                  RESET_IN,
    input  logic                  UART_SEND_TRIGGER_IN,
    input  logic [7:0]            UART_SEND_BYTE_IN,
    output logic                  UART_SEND_BUSY,
    input  logic                  SINK_BUSY_IN,
    output logic                  UART_SEND_TRIGGER,
    output logic [7:0]            UART_SEND_BYTE,
    output logic [DEPTH_LOG2:0]   QUEUE_LEVEL,
    output logic                  OVERFLOW,
    output logic [1:0]            fsm_state
);

    // Handshake: UART_SEND_TRIGGER pulses for one cycle per byte. The sink may
    // raise SINK_BUSY_IN within BUSY_WAIT cycles; if it does, the next byte
    // waits until busy drops, otherwise the byte is taken as accepted.

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int WAIT_W = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        ACKWAIT = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t                state;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic [DEPTH_LOG2:0]   level_next;
    logic [WAIT_W-1:0]     wait_cnt;
    logic                  full;
    logic                  wr_en;
    logic                  pop;

    // Full is taken from the registered level, so a pop in the same cycle
    // does not rescue a write that arrives while full.
    assign full  = (level == FULL_LEVEL);
    assign wr_en = UART_SEND_TRIGGER_IN && !full;
    assign pop   = (state == IDLE) && (level != '0) && !SINK_BUSY_IN;

    always_comb begin
        level_next = level;
        if (wr_en && !pop) begin
            level_next = level + 1'b1;
        end else if (!wr_en && pop) begin
            level_next = level - 1'b1;
        end
    end

    always_ff @(posedge MCLK_IN) begin
        if (wr_en) begin
            mem[wr_ptr] <= UART_SEND_BYTE_IN;
        end
    end

    always_ff @(posedge MCLK_IN) begin
        if (RESET_IN) begin
            state             <= IDLE;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            level             <= '0;
            wait_cnt          <= '0;
            UART_SEND_TRIGGER <= 1'b0;
            UART_SEND_BYTE    <= 8'h00;
            UART_SEND_BUSY    <= 1'b0;
            OVERFLOW          <= 1'b0;
        end else begin
            UART_SEND_TRIGGER <= 1'b0;
            level             <= level_next;
            UART_SEND_BUSY    <= (level_next == FULL_LEVEL);
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (UART_SEND_TRIGGER_IN && full) begin
                OVERFLOW <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        UART_SEND_BYTE    <= mem[rd_ptr];
                        UART_SEND_TRIGGER <= 1'b1;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ACKWAIT;
                end
                ACKWAIT: begin
                    if (SINK_BUSY_IN) begin
                        state <= DRAIN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!SINK_BUSY_IN) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign QUEUE_LEVEL = level;
    assign fsm_state   = state;

endmodule

// File: tb/tb_uart_send_queue.sv
// Directed bench for uart_send_queue: latency, fill/overflow, spacing, reset in DRAIN, pointer wrap.
// A negedge monitor compares every triggered byte against an expected queue.
module tb_uart_send_queue;

    logic       mclk;
    logic       rst;
    logic       trig_in;
    logic [7:0] byte_in;
    logic       send_busy;
    logic       sink_busy;
    logic       trig_out;
    logic [7:0] byte_out;
    logic [4:0] level;
    logic       overflow;
    logic [1:0] fsm_state;

    logic       manual_busy;
    logic       auto_sink;
    logic       auto_busy;
    int         auto_hold;
    int         auto_cnt;

    int         n_checks;
    int         n_fail;
    int         cyc;
    int         max_level;
    logic [7:0] exp_q[$];
    int         trig_cyc[$];

    assign sink_busy = manual_busy | auto_busy;

    uart_send_queue #(.DEPTH_LOG2(4), .BUSY_WAIT(8)) dut (
        .MCLK_IN              (mclk),
        .RESET_IN             (rst),
        .UART_SEND_TRIGGER_IN (trig_in),
        .UART_SEND_BYTE_IN    (byte_in),
        .UART_SEND_BUSY       (send_busy),
        .SINK_BUSY_IN         (sink_busy),
        .UART_SEND_TRIGGER    (trig_out),
        .UART_SEND_BYTE       (byte_out),
        .QUEUE_LEVEL          (level),
        .OVERFLOW             (overflow),
        .fsm_state            (fsm_state)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic step();
        @(posedge mclk);
        @(negedge mclk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b, input logic accepted);
        trig_in = 1'b1;
        byte_in = b;
        if (accepted) exp_q.push_back(b);
        step();
        trig_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (exp_q.size() == 0 && level == 5'd0 && fsm_state == 2'd0) begin
                done = 1'b1;
                break;
            end
            step();
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic check_gaps(input string tag, input int gap);
        for (int k = 1; k < trig_cyc.size(); k++) begin
            check(tag, trig_cyc[k] - trig_cyc[k-1], gap);
        end
    endtask

    // Sink model: raises busy on seeing a trigger and holds it for auto_hold sampled edges.
    always @(negedge mclk) begin
        if (auto_sink && trig_out === 1'b1) auto_cnt = auto_hold;
        else if (auto_cnt > 0) auto_cnt = auto_cnt - 1;
        auto_busy = (auto_cnt != 0);
    end

    always @(negedge mclk) begin
        logic [7:0] exp_b;
        cyc++;
        if (int'(level) > max_level) max_level = int'(level);
        if (trig_out === 1'b1) begin
            trig_cyc.push_back(cyc);
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL trig_unexpected: observed byte 0x%0h expected no trigger", byte_out);
            end
            if (exp_q.size() != 0) begin
                exp_b = exp_q.pop_front();
                check("sent_byte", {24'd0, byte_out}, {24'd0, exp_b});
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        max_level = 0;
        rst = 1'b1;
        trig_in = 1'b0;
        byte_in = 8'h00;
        manual_busy = 1'b0;
        auto_sink = 1'b0;
        auto_busy = 1'b0;
        auto_hold = 2;
        auto_cnt = 0;

        // Reset state
        step();
        step();
        rst = 1'b0;
        check("rst_level", level, 0);
        check("rst_busy", send_busy, 0);
        check("rst_trig", trig_out, 0);
        check("rst_byte", byte_out, 8'h00);
        check("rst_ovf", overflow, 0);
        check("rst_state", fsm_state, 0);

        // Single byte, idle sink: trigger two edges after the strobe
        write_byte(8'h41, 1'b1);
        check("lat_level1", level, 1);
        check("lat_trig_e0", trig_out, 0);
        step();
        check("lat_trig_e1", trig_out, 1);
        check("lat_byte", byte_out, 8'h41);
        check("lat_level0", level, 0);
        check("lat_state_issue", fsm_state, 1);
        step();
        check("lat_trig_e2", trig_out, 0);
        check("lat_state_ack", fsm_state, 2);
        for (int k = 0; k < 7; k++) step();
        check("ackwait_hold", fsm_state, 2);
        step();
        check("ackwait_timeout", fsm_state, 0);
        check("byte_held", byte_out, 8'h41);

        // Fill with sink busy, then overflow
        manual_busy = 1'b1;
        for (int i = 0; i < 15; i++) write_byte(8'(i), 1'b1);
        check("fill15_level", level, 15);
        check("fill15_busy", send_busy, 0);
        write_byte(8'h0F, 1'b1);
        check("fill16_level", level, 16);
        check("fill16_busy", send_busy, 1);
        check("fill16_ovf", overflow, 0);
        write_byte(8'hEE, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_level", level, 16);
        check("ovf_state", fsm_state, 0);
        trig_cyc.delete();
        manual_busy = 1'b0;
        wait_idle("drain16_done", 400);
        check("drain16_count", trig_cyc.size(), 16);
        check_gaps("gap_no_busy", 10);
        check("ovf_sticky", overflow, 1);
        check("drain_busy", send_busy, 0);

        // Reset while in DRAIN with 5 bytes queued
        for (int i = 0; i < 6; i++) begin
            write_byte(8'(8'h50 + i), i == 0);
            if (i == 1) manual_busy = 1'b1;
        end
        check("pre_rst_level", level, 5);
        check("pre_rst_state", fsm_state, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_level", level, 0);
        check("mid_rst_state", fsm_state, 0);
        check("mid_rst_trig", trig_out, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_byte", byte_out, 8'h00);
        manual_busy = 1'b0;
        trig_cyc.delete();
        for (int k = 0; k < 30; k++) step();
        check("no_stale_send", trig_cyc.size(), 0);

        // Minimum spacing with a sink that answers at once
        auto_sink = 1'b1;
        auto_hold = 2;
        trig_cyc.delete();
        for (int i = 0; i < 4; i++) write_byte(8'(8'h60 + i), 1'b1);
        wait_idle("fast_done", 200);
        check("fast_count", trig_cyc.size(), 4);
        check_gaps("gap_fast", 4);

        // Pointer wrap with interleaved sink traffic
        auto_hold = 3;
        max_level = 0;
        trig_cyc.delete();
        for (int i = 0; i < 40; i++) begin
            write_byte(8'(i * 37 + 5), 1'b1);
            step();
            step();
            step();
        end
        wait_idle("wrap_done", 400);
        check("wrap_count", trig_cyc.size(), 40);
        check("wrap_max_level", {31'd0, max_level <= 16}, 1);
        check("wrap_ovf", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
